spi_bus_arbiter: RTL
====================

Name: spi_bus_arbiter

Overview:
- Shares one SPI byte engine (8-bit shift, 4-bit clock divider, send/taken/avail/busy handshake) between NREQ requesters.
- Each requester owns one active-low chip select and a 4-bit clock-divide value.
- A transaction is a burst of bytes with CS held low until the byte flagged last completes.
- Round-robin arbitration at transaction boundaries only; sits between the SD/flash/peripheral clients and the SPI byte engine.

Parameters:
NREQ, 2, number of requesters (1..4)
CS_SETUP, 2, iClk cycles from CS low to first byte send
CS_HOLD, 2, iClk cycles from last byte avail to CS high
TIMEOUT, 255, inter-byte idle limit in iClk cycles (optional feature only)

Ports:
iClk  in  1  clock
iRstN  in  1  synchronous active-low reset
iReq  in  NREQ  requester i has a byte ready on its iTxData slice
iLast  in  NREQ  byte presented by requester i ends its transaction
iTxData  in  NREQ*8  tx byte per requester, slice i = [8i+7:8i]
iClkDiv  in  NREQ*4  SPI divide per requester, slice i = [4i+3:4i]
oTaken  out  NREQ  1-cycle pulse: requester i's byte accepted
oRxValid  out  NREQ  1-cycle pulse: oRxData valid for requester i
oRxData  out  8  received byte (shared)
oGrant  out  NREQ  one-hot current owner, 0 when idle
oCsN  out  NREQ  active-low chip selects
oSpiSend  out  1  to engine send strobe
oSpiData  out  8  to engine tx byte
oSpiClkDiv  out  4  to engine divide
iSpiData  in  8  engine rx byte
iSpiAvail  in  1  engine rx-available pulse
iSpiTaken  in  1  engine byte-taken pulse
iSpiBusy  in  1  engine busy
oAbort  out  NREQ  1-cycle pulse: transaction aborted (optional feature only, else tied 0)

Behaviour:
- Clock/reset: one clock iClk; reset synchronous, active-low (iRstN). Reset values: oCsN all 1, oGrant 0, oSpiSend 0, oTaken/oRxValid/oAbort 0, oRxData 0, oSpiData 0, oSpiClkDiv 0, rr pointer 0, state IDLE.
- Reset mid-transaction: CS released the next edge. The engine has no reset, so state RECOVER waits for iSpiBusy==0 and one clear cycle before IDLE; any iSpiAvail seen in RECOVER is discarded.
- IDLE:
  - Requires iSpiBusy==0.
  - Pick first i with iReq[i]=1, scanning from rr pointer upward with wrap.
  - Latch owner; set oGrant; latch oSpiClkDiv from that slice; drive oCsN[owner]=0; go to SETUP.
- SETUP: count CS_SETUP cycles, then go to SEND. CS_SETUP=0 goes directly to SEND.
- SEND:
  - If iReq[owner]=1: drive oSpiSend=1, oSpiData=iTxData slice, latch iLast[owner]; hold until iSpiTaken.
  - On iSpiTaken: pulse oTaken[owner] that same cycle, drop oSpiSend, go to XFER.
  - Requester must hold data/last stable while iReq=1 and oTaken=0.
- XFER:
  - On iSpiAvail: oRxData<=iSpiData and pulse oRxValid[owner] the next cycle.
  - If latched last=1, go to HOLD; else go to SEND (CS stays low).
- HOLD: count CS_HOLD cycles, then oCsN all 1, oGrant 0, rr pointer = owner+1 mod NREQ, go to IDLE.
- Latency: first oSpiSend is CS_SETUP+1 cycles after grant. Minimum gap between transactions to different owners is 1 IDLE cycle.
- Simultaneous requests: lowest index at or after the rr pointer wins. Non-owners are never granted mid-transaction.
- Owner drops iReq mid-burst (no last): arbiter stays in SEND holding CS low indefinitely (without the optional feature).
- iReq on a non-owner: ignored until HOLD completes; no oTaken pulse.
- At most one of oTaken bits is set per cycle; the same holds for oRxValid.
- iClkDiv change mid-transaction is ignored; the divide is latched at grant.
- NREQ=1: rr pointer is constant 0.

Optional Feature:
SPI_ARB_TIMEOUT_EN
- Defined:
  - In SEND with iReq[owner]=0, an 8-bit counter increments each cycle; it is cleared whenever it leaves SEND.
  - When the counter reaches TIMEOUT: pulse oAbort[owner], go to HOLD (normal CS_HOLD, rr advance).
- Undefined: no counter; oAbort driven 0; arbiter waits indefinitely.

Test Plan:
- Reset, iReq=01, iTxData[7:0]=A5, iLast=1, div=2, CS_SETUP=2, engine model loops back -> oCsN[0] low, oSpiSend high 3 cycles after grant, oTaken[0] 1 pulse, oRxValid[0] with oRxData=A5, then oCsN[0] high after 2 hold cycles, oGrant=0.
- Requester 0 sends 3-byte burst 01,02,03, last on 03 -> oCsN[0] stays low across all 3 bytes, exactly 3 oTaken and 3 oRxValid pulses.
- iReq=11 asserted together from reset, single-byte transactions repeated -> grants alternate 0,1,0,1; oCsN never both low.
- During owner 0 burst, requester 1 raises iReq -> no oTaken[1] until owner 0's last byte HOLD completes; then grant 1.
- Assert iRstN=0 while engine busy mid-byte -> oCsN all 1 next cycle; no oSpiSend until iSpiBusy=0; stale iSpiAvail yields no oRxValid.
- With SPI_ARB_TIMEOUT_EN, TIMEOUT=10, owner drops iReq after byte 1 without last -> oAbort[0] pulse 10 cycles into SEND, CS released; without macro, CS held low after 1000 cycles.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
// Shares one SPI byte engine between NREQ requesters. A requester owns the
// engine for a whole transaction (burst of bytes, CS held low until the byte
// flagged last completes). Arbitration is round-robin and only happens at
// transaction boundaries.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   When defined, an owner that stays idle in SEND for TIMEOUT cycles has its
//   transaction aborted (oAbort pulse, normal CS hold, rr advance).
//   When undefined, oAbort is tied 0 and the arbiter waits indefinitely.
//
// Ports:
//   iClk, iRstN          clock, synchronous active-low reset
//   iReq/iLast           per-requester byte-ready and end-of-transaction flags
//   iTxData/iClkDiv      per-requester tx byte (8 bits) and SPI divide (4 bits)
//   oTaken/oRxValid      per-requester 1-cycle pulses (byte accepted / rx valid)
//   oRxData              shared received byte
//   oGrant/oCsN          one-hot owner, active-low chip selects
//   oSpiSend/Data/ClkDiv to the byte engine
//   iSpiData/Avail/Taken/Busy from the byte engine
//   oAbort               per-requester timeout abort pulse
module spi_bus_arbiter #(
  parameter int NREQ     = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic [NREQ-1:0]   iReq,
  input  logic [NREQ-1:0]   iLast,
  input  logic [NREQ*8-1:0] iTxData,
  input  logic [NREQ*4-1:0] iClkDiv,
  output logic [NREQ-1:0]   oTaken,
  output logic [NREQ-1:0]   oRxValid,
  output logic [7:0]        oRxData,
  output logic [NREQ-1:0]   oGrant,
  output logic [NREQ-1:0]   oCsN,
  output logic              oSpiSend,
  output logic [7:0]        oSpiData,
  output logic [3:0]        oSpiClkDiv,
  input  logic [7:0]        iSpiData,
  input  logic              iSpiAvail,
  input  logic              iSpiTaken,
  input  logic              iSpiBusy,
  output logic [NREQ-1:0]   oAbort
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Setup, hold and timeout all share one 8-bit cycle counter.
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  if (NREQ < 1 || NREQ > 4 || CS_SETUP < 0 || CS_SETUP > 255 ||
      CS_HOLD < 0 || CS_HOLD > 255 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("spi_bus_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SEND, S_XFER, S_HOLD, S_RECOVER
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d, rr_q, rr_d, rr_next, pick_idx;
  logic [NREQ-1:0] grant_q, grant_d, csn_q, csn_d, rxv_q, rxv_d, pick_oh;
  logic            send_q, send_d, last_q, last_d, rec_q, rec_d;
  logic [7:0]      data_q, data_d, rx_q, rx_d, cnt_q, cnt_d;
  logic [3:0]      div_q, div_d;
  logic            pick_found, enter_hold, release_bus;
  logic [7:0]      tx_byte [NREQ];
  logic [3:0]      div_val [NREQ];

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [NREQ-1:0] abort_q, abort_d;
`endif

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign tx_byte[gi] = iTxData[8*gi +: 8];
    assign div_val[gi] = iClkDiv[4*gi +: 4];
  end

  assign rr_next = PW'((int'(owner_q) + 1) % NREQ);

  // Round-robin pick: first requester at or after rr_q, with wrap.
  always_comb begin
    logic [PW-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(rr_q) + k) % NREQ);
      if (!pick_found && iReq[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_oh[pick_idx] = pick_found;
  end

  // State register and datapath registers.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      // The engine is not reset with us: if a byte may be in flight, drain it
      // in RECOVER before arbitrating again.
      if (state_q == S_SEND || state_q == S_XFER || state_q == S_RECOVER)
        state_q <= S_RECOVER;
      else
        state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      csn_q   <= '1;
      rxv_q   <= '0;
      send_q  <= 1'b0;
      last_q  <= 1'b0;
      rec_q   <= 1'b0;
      data_q  <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      abort_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      csn_q   <= csn_d;
      rxv_q   <= rxv_d;
      send_q  <= send_d;
      last_q  <= last_d;
      rec_q   <= rec_d;
      data_q  <= data_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
`ifdef SPI_ARB_TIMEOUT_EN
      abort_q <= abort_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    csn_d       = csn_q;
    rxv_d       = '0;
    send_d      = send_q;
    last_d      = last_q;
    rec_d       = 1'b0;
    data_d      = data_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    enter_hold  = 1'b0;
    release_bus = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    abort_d     = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!iSpiBusy && pick_found) begin
          owner_d = pick_idx;
          grant_d = pick_oh;
          csn_d   = ~pick_oh;
          div_d   = div_val[pick_idx];
          last_d  = 1'b0;
          cnt_d   = '0;
          state_d = (CS_SETUP == 0) ? S_SEND : S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SEND: begin
        // oSpiSend is registered, so the first strobe lands CS_SETUP+1 cycles
        // after grant.
        if (send_q) begin
          if (iSpiTaken) begin
            send_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_XFER;
          end
        end else if (iReq[owner_q]) begin
          send_d = 1'b1;
          data_d = tx_byte[owner_q];
          last_d = iLast[owner_q];
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          abort_d    = grant_q;
          enter_hold = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_XFER: begin
        if (iSpiAvail) begin
          rx_d  = iSpiData;
          rxv_d = grant_q;
          if (last_q) enter_hold = 1'b1;
          else        state_d    = S_SEND;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) release_bus = 1'b1;
        else                    cnt_d       = cnt_q + 8'd1;
      end
      S_RECOVER: begin
        // Need the engine idle for two consecutive cycles; avail is dropped.
        rec_d = !iSpiBusy;
        if (!iSpiBusy && rec_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_hold) begin
      cnt_d = '0;
      if (CS_HOLD == 0) release_bus = 1'b1;
      else              state_d     = S_HOLD;
    end
    if (release_bus) begin
      csn_d   = '1;
      grant_d = '0;
      rr_d    = rr_next;
      state_d = S_IDLE;
    end
  end

  // Outputs.
  always_comb begin
    oTaken = '0;
    if (state_q == S_SEND && send_q && iSpiTaken) oTaken = grant_q;
  end

  assign oRxValid   = rxv_q;
  assign oRxData    = rx_q;
  assign oGrant     = grant_q;
  assign oCsN       = csn_q;
  assign oSpiSend   = send_q;
  assign oSpiData   = data_q;
  assign oSpiClkDiv = div_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign oAbort     = abort_q;
`else
  assign oAbort     = '0;
`endif
endmodule
